// File: rtl/kernel_jacobi_2d_pkg.sv
// Shared widths, tag and stage types for the jacobi-2d multiplier arbiter.
// Also holds the truncating unsigned multiply used by the pipeline.
package kernel_jacobi_2d_pkg;

  localparam int NUM_REQ_D = 4;
  localparam int A_W       = 10;
  localparam int B_W       = 11;
  localparam int P_W       = 20;
  localparam int AB_W      = A_W + B_W;
  localparam int PAY_W     = (AB_W > P_W) ? AB_W : P_W;

  typedef logic [NUM_REQ_D-1:0] tag_t;

  typedef struct packed {
    logic             valid;
    tag_t             tag;
    logic [PAY_W-1:0] payload;
  } stage_t;

  function automatic logic [P_W-1:0] mul_trunc(
    input logic [A_W-1:0] a,
    input logic [B_W-1:0] b
  );
    logic [AB_W-1:0] full;
    full = AB_W'(a) * AB_W'(b);
    return full[P_W-1:0];
  endfunction

endpackage

// File: rtl/kernel_jacobi_2d_rr_arb.sv
// Round-robin arbiter: grants the first requester after the last winner.
// The pointer moves only when a grant is actually issued.
module kernel_jacobi_2d_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [LW-1:0]      last;
  logic [LW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] pick;
  int                 idx;

  // Scan lowest priority first so the highest-priority hit wins last.
  always_comb begin
    pick     = '0;
    pick_idx = last;
    idx      = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
        pick_idx  = LW'(idx);
      end
    end
  end

  assign gnt = en ? pick : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= LW'(NUM_REQ - 1);
    end else if (|gnt) begin
      last <= pick_idx;
    end
  end

endmodule

// File: rtl/kernel_jacobi_2d_mul_arb.sv
// Shared multiplier front end: round-robin operand intake, registered
// multiply pipeline, one-hot tagged results, global stall on backpressure.
module kernel_jacobi_2d_mul_arb
  import kernel_jacobi_2d_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_D,
  parameter int A_WIDTH    = A_W,
  parameter int B_WIDTH    = B_W,
  parameter int P_WIDTH    = P_W,
  parameter int MUL_STAGES = 2
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [P_WIDTH-1:0]         rsp_p,
  input  logic                       rsp_ready
);

  localparam int L = MUL_STAGES - 1;

  stage_t             st  [MUL_STAGES];
  stage_t             nxt [MUL_STAGES];
  logic               stall;
  logic               en;
  logic [NUM_REQ-1:0] gnt;
  logic [A_WIDTH-1:0] sel_a;
  logic [B_WIDTH-1:0] sel_b;

  assign rsp_valid = st[L].valid ? st[L].tag : '0;
  assign rsp_p     = st[L].payload[P_WIDTH-1:0];
  assign stall     = (|rsp_valid) & ~rsp_ready;
  assign en        = ~stall & ~ap_rst;
  assign req_ready = gnt;

  kernel_jacobi_2d_rr_arb #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk(ap_clk),
    .rst(ap_rst),
    .en (en),
    .req(req_valid),
    .gnt(gnt)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*A_WIDTH +: A_WIDTH];
        sel_b = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  // Stage 1 keeps raw operands unless it is also the output stage.
  always_comb begin
    for (int k = 0; k < MUL_STAGES; k++) begin
      nxt[k] = st[k];
    end
    nxt[0].valid = |gnt;
    nxt[0].tag   = gnt;
    if (MUL_STAGES == 1) begin
      nxt[0].payload = PAY_W'(mul_trunc(sel_a, sel_b));
    end else begin
      nxt[0].payload = PAY_W'({sel_a, sel_b});
    end
    for (int k = 1; k < MUL_STAGES; k++) begin
      nxt[k] = st[k-1];
      if (k == 1) begin
        nxt[k].payload = PAY_W'(mul_trunc(
          st[0].payload[AB_W-1 -: A_W],
          st[0].payload[B_W-1:0]));
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int k = 0; k < MUL_STAGES; k++) begin
        st[k] <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k < MUL_STAGES; k++) begin
        st[k] <= nxt[k];
      end
    end
  end

endmodule

// File: tb/tb_kernel_jacobi_2d_mul_arb.sv
// Randomized and directed bench for kernel_jacobi_2d_mul_arb.
// Reference model: queue of in-flight results aged by non-stall edges.
module tb_kernel_jacobi_2d_mul_arb;

  localparam int N = 4;
  localparam int S = 2;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*10-1:0] req_a;
  logic [N*11-1:0] req_b;
  logic [N-1:0]  rsp_valid;
  logic [19:0]   rsp_p;
  logic          rsp_ready;

  kernel_jacobi_2d_mul_arb dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_p    (rsp_p),
    .rsp_ready(rsp_ready)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int          tag;
    logic [19:0] p;
    int          age;
  } ent_t;

  ent_t        q[$];
  int          m_last;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          seen2   = 0;
  logic [9:0]  ta [N];
  logic [10:0] tb [N];
  logic [N-1:0] obs_rdy;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] ref_mul(input int a, input int b);
    longint full;
    full = longint'(a) * longint'(b);
    return 20'(full % (longint'(1) << 20));
  endfunction

  // One cycle: drive, check outputs against the model, clock, update model.
  task automatic step(input logic rst, input logic [N-1:0] v,
                      input logic rr);
    logic [N-1:0] ev;
    logic [N-1:0] eg;
    logic [19:0]  ep;
    logic         stl;
    int           oi;
    int           win;
    int           idx;
    ap_rst    = rst;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_a[i*10 +: 10] = ta[i];
      req_b[i*11 +: 11] = tb[i];
    end
    #1;
    ev = '0;
    ep = '0;
    oi = -1;
    for (int k = 0; k < q.size(); k++) begin
      if (q[k].age == S) begin
        ev = N'(1 << q[k].tag);
        ep = q[k].p;
        oi = k;
      end
    end
    stl = (ev != '0) && !rr;
    win = -1;
    if (!rst && !stl) begin
      for (int off = 1; off <= N; off++) begin
        idx = (m_last + off) % N;
        if (win < 0 && v[idx]) win = idx;
      end
    end
    eg = (win >= 0) ? N'(1 << win) : '0;
    obs_rdy = req_ready;
    if (rsp_valid == 4'b0100) seen2++;
    chk("req_ready", 32'(req_ready), 32'(eg));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev != '0) chk("rsp_p", 32'(rsp_p), 32'(ep));
    @(posedge ap_clk);
    if (rst) begin
      q.delete();
      m_last = N - 1;
    end else if (!stl) begin
      if (oi >= 0) q.delete(oi);
      for (int k = 0; k < q.size(); k++) q[k].age++;
      if (win >= 0) begin
        q.push_back('{tag: win, p: ref_mul(int'(ta[win]), int'(tb[win])),
                      age: 1});
        m_last = win;
      end
    end
    @(negedge ap_clk);
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    ta[i] = 10'(a);
    tb[i] = 11'(b);
  endtask

  logic [19:0] hold_p;
  logic [N-1:0] hold_v;

  initial begin
    ap_rst    = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) set_ops(i, 0, 0);
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    m_last = N - 1;
    req_valid = '1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_p", 32'(rsp_p), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    @(negedge ap_clk);

    // single requester, max operands
    set_ops(0, 1023, 2047);
    step(0, 4'b0001, 1);
    chk("first_grant", 32'(obs_rdy), 32'h1);
    step(0, 4'b0000, 1);
    chk("lat_valid", 32'(rsp_valid), 32'h1);
    chk("lat_p", 32'(rsp_p), 32'hFF401);
    repeat (3) step(0, 4'b0000, 1);

    // full rotation from reset
    step(1, 4'b0000, 1);
    for (int i = 0; i < N; i++) set_ops(i, i + 1, 3);
    for (int c = 0; c < 8; c++) begin
      step(0, 4'b1111, 1);
      chk("rot_order", 32'(obs_rdy), 32'(1 << (c % N)));
    end
    repeat (3) step(0, 4'b0000, 1);

    // backpressure on a full pipeline
    repeat (4) step(0, 4'b1111, 1);
    hold_p = rsp_p;
    hold_v = rsp_valid;
    for (int c = 0; c < 3; c++) begin
      step(0, 4'b1111, 0);
      chk("stall_rdy", 32'(obs_rdy), 32'h0);
      chk("stall_v", 32'(rsp_valid), 32'(hold_v));
      chk("stall_p", 32'(rsp_p), 32'(hold_p));
    end
    repeat (4) step(0, 4'b0000, 1);

    // skip idle requesters
    step(0, 4'b1000, 1);
    chk("skip_g3", 32'(obs_rdy), 32'h8);
    step(0, 4'b1010, 1);
    chk("skip_g1", 32'(obs_rdy), 32'h2);
    repeat (3) step(0, 4'b0000, 1);

    // reset with results in flight
    repeat (2) step(0, 4'b1111, 1);
    step(1, 4'b0000, 1);
    chk("rst_flush", 32'(rsp_valid), 32'h0);
    repeat (4) step(0, 4'b0000, 1);
    step(0, 4'b1111, 1);
    chk("post_rst_g0", 32'(obs_rdy), 32'h1);
    repeat (3) step(0, 4'b0000, 1);

    // requester 2 withdraws before it is served
    step(1, 4'b0000, 1);
    seen2 = 0;
    step(0, 4'b0101, 1);
    step(0, 4'b0110, 1);
    step(0, 4'b1000, 1);
    step(0, 4'b0001, 1);
    repeat (4) step(0, 4'b0000, 1);
    chk("no_tag2", 32'(seen2), 32'h0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        set_ops(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 2047)));
      step(($urandom_range(0, 49) == 0), N'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0));
    end
    repeat (4) step(0, 4'b0000, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
